// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program-counter unit. Holds the byte address of the current instruction,
// selects the next PC from sequential, branch, jump and jump-register
// targets, counts retired instructions and detects a self-loop redirect,
// which stops the machine (HALT).
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high reset
//   PCSel[1:0]   next-PC select: 00 seq, 01 branch, 10 jump, 11 jump-register
//   BrNe         branch sense: 0 = beq (taken on Zero), 1 = bne (taken on !Zero)
//   Zero         ALU zero flag of the current instruction
//   imm[15:0]    branch offset in words, two's complement
//   addr[25:0]   jump target word index
//   RegA[31:0]   register value for jump-register
//   stall        1 freezes the PC for this cycle
//   PC[31:0]     current byte address
//   halted       1 while in HALT (registered)
//   err          sticky misaligned jump-register flag
//   instr_count  retired-instruction count, saturating
// ---------------------------------------------------------------------------
module pc_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  PCSel,
   input  logic        BrNe,
   input  logic        Zero,
   input  logic [15:0] imm,
   input  logic [25:0] addr,
   input  logic [31:0] RegA,
   input  logic        stall,
   output logic [31:0] PC,
   output logic        halted,
   output logic        err,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   state_t state;

   // Counter saturates rather than wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic        [31:0] pc4;
   logic signed [31:0] br_off;
   logic        [31:0] br_tgt;
   logic        [31:0] jmp_tgt;
   logic        [31:0] jr_tgt;
   logic               br_taken;
   logic               jr_misaligned;
   logic        [31:0] target;
   logic               redirect;

   assign pc4     = PC + 32'd4;
   // Word offset sign-extended and scaled to bytes.
   assign br_off  = {{14{imm[15]}}, imm, 2'b00};
   assign br_tgt  = pc4 + $unsigned(br_off);
   assign jmp_tgt = {pc4[31:28], addr, 2'b00};
   assign jr_tgt  = {RegA[31:2], 2'b00};

   assign br_taken      = (PCSel == 2'b01) && (Zero ^ BrNe);
   assign jr_misaligned = (PCSel == 2'b11) && (RegA[1:0] != 2'b00);

   // A not-taken branch falls through to PC4 and is not a redirect, so it
   // can never trigger HALT.
   always_comb begin
      target   = pc4;
      redirect = 1'b0;
      case (PCSel)
         2'b01: begin
            if (br_taken) begin
               target   = br_tgt;
               redirect = 1'b1;
            end
         end
         2'b10: begin
            target   = jmp_tgt;
            redirect = 1'b1;
         end
         2'b11: begin
            target   = jr_tgt;
            redirect = 1'b1;
         end
         default: begin
            target   = pc4;
            redirect = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= BOOT;
         PC          <= 32'd0;
         halted      <= 1'b0;
         err         <= 1'b0;
         instr_count <= 32'd0;
      end else begin
         case (state)
            BOOT: state <= RUN;
            RUN: begin
               if (!stall) begin
                  instr_count <= sat_inc(instr_count);
                  if (jr_misaligned)
                     err <= 1'b1;
                  // A redirect back onto itself is a self-loop: stop here.
                  if (redirect && (target == PC)) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     PC <= target;
                  end
               end
            end
            HALT: state <= HALT;
            default: begin
               state  <= BOOT;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 PCSel  input  2  next-PC select from the instruction parser: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-005 BrNe  input  1  branch sense: 0 = taken on Zero=1 (beq), 1 = taken on Zero=0 (bne).
REQ-006 Zero  input  1  ALU zero flag of the current instruction.
REQ-007 imm  input  16  branch offset in words, two's complement.
REQ-008 addr  input  26  jump target word index.
REQ-009 RegA  input  32  register value for jump-register.
REQ-010 stall  input  1  hold request; 1 freezes PC for that cycle.
REQ-011 PC  output  32  current byte address presented to the instruction parser.
REQ-012 halted  output  1  1 while in HALT.
REQ-013 err  output  1  sticky misaligned jump-register flag.
REQ-014 instr_count  output  32  number of instructions retired.

Function
REQ-015 The block SHALL implement states BOOT, RUN, HALT; state, PC, err and instr_count update only on rising clk.
REQ-016 BOOT SHALL last exactly one cycle after reset deassertion: PC held at 0, count not incremented, next state RUN regardless of inputs.
REQ-017 The block SHALL compute PC4 = PC + 4, modulo 2^32 (wraps FFFFFFFC -> 00000000).
REQ-018 Branch target SHALL be PC4 + (sign-extended imm << 2), modulo 2^32.
REQ-019 Jump target SHALL be {PC4[31:28], addr, 2'b00}.
REQ-020 Jump-register target SHALL be {RegA[31:2], 2'b00}.
REQ-021 Branch taken SHALL equal (PCSel==01) and (Zero XOR BrNe); not taken SHALL select PC4.
REQ-022 In RUN with stall=0, the next PC SHALL be the target selected by PCSel (one-cycle latency, loaded at the next edge) and instr_count SHALL increment by 1.
REQ-023 In RUN with stall=1, PC, instr_count and err SHALL hold, and all other inputs SHALL be ignored.
REQ-024 instr_count SHALL saturate at FFFFFFFF, with no wrap.
REQ-025 In RUN with stall=0, a jump-register whose RegA[1:0] != 00 SHALL set err at the next edge; err SHALL clear only on reset, and execution SHALL continue.
REQ-026 In RUN with stall=0, a taken redirect (branch taken, jump or jump-register) whose target equals the current PC SHALL move the state to HALT, keep PC unchanged and increment instr_count once.
REQ-027 Sequential PC4 SHALL never trigger HALT.
REQ-028 In HALT, PC and instr_count SHALL hold, halted=1, and all inputs including stall SHALL be ignored; only reset exits HALT.
REQ-029 halted SHALL be 0 in BOOT and RUN, and SHALL be registered, rising in the same cycle the state enters HALT.

Reset
REQ-030 Assertion of reset SHALL immediately, without waiting for clk, force PC=00000000, state=BOOT, halted=0, err=0, instr_count=0.
REQ-031 Reset asserted mid-operation, including in HALT or during stall, SHALL produce the REQ-030 values, and the block SHALL restart with BOOT.

Verification
REQ-032 Sequential run: reset, release, 4 edges with PCSel=00 and stall=0 -> PC sequence 0, 0 (BOOT), 4, 8, C; instr_count=3.
REQ-033 Branch: at PC=8, PCSel=01, BrNe=0, Zero=1, imm=FFFE -> next PC=4; repeat with Zero=0 -> next PC=C.
REQ-034 Jump and jump-register: at PC=10, PCSel=10, addr=0000040 -> PC=00000100; then PCSel=11, RegA=00000203 -> PC=00000200 and err=1 persists afterwards.
REQ-035 Stall: at PC=C, stall=1 for 3 edges with PCSel=10 -> PC=C and instr_count unchanged; stall=0 -> jump taken next edge.
REQ-036 Halt: at PC=20, PCSel=01, BrNe=0, Zero=1, imm=FFFF -> halted=1, PC=20 held for 5 further edges under arbitrary inputs; instr_count incremented once.
REQ-037 Async reset: assert reset between edges while halted -> PC=0, halted=0, err=0, instr_count=0 before the next clk edge.
